// File: rtl/fpu_req_issuer.sv
// rtl/fpu_req_issuer.sv - FPU request issuer: request FIFO, tagged issue, per-tag result scoreboard (optional stall: FPU_ISSUER_RAND_STALL_EN)
module fpu_req_issuer #(
    parameter int NUM_OPERANDS = 3,
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 4,
    parameter int TAG_W        = 2,
    parameter int CNT_W        = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic [NUM_OPERANDS*WIDTH-1:0] i_req_operands,
    input  logic [3:0]                    i_req_op,
    input  logic                          i_req_op_mod,
    input  logic [2:0]                    i_req_rnd_mode,
    input  logic [2:0]                    i_req_src_fmt,
    input  logic [2:0]                    i_req_dst_fmt,
    input  logic [1:0]                    i_req_int_fmt,
    input  logic [WIDTH-1:0]              i_req_exp,
    output logic [NUM_OPERANDS*WIDTH-1:0] o_fpu_operands,
    output logic [3:0]                    o_fpu_op,
    output logic                          o_fpu_op_mod,
    output logic [2:0]                    o_fpu_rnd_mode,
    output logic [2:0]                    o_fpu_src_fmt,
    output logic [2:0]                    o_fpu_dst_fmt,
    output logic [1:0]                    o_fpu_int_fmt,
    output logic                          o_fpu_vectorial,
    output logic [TAG_W-1:0]              o_fpu_tag_i,
    output logic                          o_fpu_in_valid,
    input  logic                          i_fpu_in_ready,
    output logic                          o_fpu_flush,
    input  logic [WIDTH-1:0]              i_fpu_result,
    input  logic [TAG_W-1:0]              i_fpu_tag_o,
    input  logic                          i_fpu_out_valid,
    output logic                          o_fpu_out_ready,
    input  logic                          i_flush,
    output logic [CNT_W-1:0]              o_pass_cnt,
    output logic [CNT_W-1:0]              o_fail_cnt,
    output logic                          o_tag_err,
    output logic                          o_idle
);
    localparam int AW      = $clog2(DEPTH);
    localparam int OPW     = NUM_OPERANDS * WIDTH;
    localparam int ENTRY_W = OPW + 4 + 1 + 3 + 3 + 3 + 2 + WIDTH;
    localparam int NTAG    = 2 ** TAG_W;

    localparam logic [AW:0]      PTR_ONE  = (AW + 1)'(1);
    localparam logic [TAG_W:0]   OUT_ONE  = (TAG_W + 1)'(1);
    localparam logic [TAG_W:0]   OUT_MAX  = (TAG_W + 1)'(NTAG);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic [TAG_W:0]     r_outstanding;
    logic [TAG_W-1:0]   r_issue_tag;
    logic [NTAG-1:0]    r_sb_v;
    logic [WIDTH-1:0]   r_sb_exp [NTAG];
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic               r_tag_err;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_issue;
    logic               w_room;
    logic [ENTRY_W-1:0] w_head;
    logic [WIDTH-1:0]   w_head_exp;
    logic               w_ret;
    logic               w_ret_hit;
    logic               w_ret_miss;
    logic               w_match;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    assign {o_fpu_operands, o_fpu_op, o_fpu_op_mod, o_fpu_rnd_mode,
            o_fpu_src_fmt, o_fpu_dst_fmt, o_fpu_int_fmt, w_head_exp} = w_head;

    assign o_req_ready     = !w_full && !i_rst;
    assign w_push          = i_req_valid && o_req_ready && !i_flush;
    assign w_room          = (r_outstanding < OUT_MAX);
    assign o_fpu_in_valid  = !w_empty && w_room && !i_flush && !i_rst;
    assign w_issue         = o_fpu_in_valid && i_fpu_in_ready;
    assign o_fpu_tag_i     = r_issue_tag;
    assign o_fpu_vectorial = 1'b0;
    assign o_fpu_flush     = i_flush && !i_rst;

    // A result arriving during flush is discarded entirely
    assign w_ret      = i_fpu_out_valid && o_fpu_out_ready && !i_flush;
    assign w_ret_hit  = w_ret && r_sb_v[i_fpu_tag_o];
    assign w_ret_miss = w_ret && !r_sb_v[i_fpu_tag_o];
    assign w_match    = (i_fpu_result == r_sb_exp[i_fpu_tag_o]);

    assign o_pass_cnt = r_pass_cnt;
    assign o_fail_cnt = r_fail_cnt;
    assign o_tag_err  = r_tag_err;
    assign o_idle     = w_empty && (r_outstanding == '0);

`ifdef FPU_ISSUER_RAND_STALL_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb       = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign o_fpu_out_ready = r_lfsr[0];

    // Free-running LFSR (x^16+x^14+x^13+x^11+1) throttles result acceptance
    always_ff @(posedge i_clk) begin
        if (i_rst) r_lfsr <= 16'hACE1;
        else       r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
`else
    assign o_fpu_out_ready = !i_rst;
`endif

    // FIFO storage; contents need no reset since pointers gate visibility
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {i_req_operands, i_req_op, i_req_op_mod, i_req_rnd_mode,
                                      i_req_src_fmt, i_req_dst_fmt, i_req_int_fmt, i_req_exp};
        end
    end

    // FIFO pointers; flush empties by catching the read pointer up
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_rptr <= r_wptr;
        end else begin
            if (w_push)  r_wptr <= r_wptr + PTR_ONE;
            if (w_issue) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Expected value captured per tag at issue time
    always_ff @(posedge i_clk) begin
        if (w_issue) r_sb_exp[r_issue_tag] <= w_head_exp;
    end

    // Scoreboard valid bits; issue and retire never hit the same tag in one cycle
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_sb_v <= '0;
        end else begin
            if (w_issue)   r_sb_v[r_issue_tag] <= 1'b1;
            if (w_ret_hit) r_sb_v[i_fpu_tag_o] <= 1'b0;
        end
    end

    // Issue tag counter survives flush so tags keep advancing
    always_ff @(posedge i_clk) begin
        if (i_rst)        r_issue_tag <= '0;
        else if (w_issue) r_issue_tag <= r_issue_tag + TAG_ONE;
    end

    // Outstanding count; simultaneous issue and retire cancel out
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_outstanding <= '0;
        end else begin
            case ({w_issue, w_ret_hit})
                2'b10:   r_outstanding <= r_outstanding + OUT_ONE;
                2'b01:   r_outstanding <= r_outstanding - OUT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Saturating pass/fail counters and sticky unknown-tag flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_tag_err  <= 1'b0;
        end else begin
            if (w_ret_hit && w_match && (r_pass_cnt != '1))
                r_pass_cnt <= r_pass_cnt + CNT_ONE;
            if (w_ret_hit && !w_match && (r_fail_cnt != '1))
                r_fail_cnt <= r_fail_cnt + CNT_ONE;
            if (w_ret_miss)
                r_tag_err <= 1'b1;
        end
    end
endmodule
